// File: rtl/ac_stream_matcher.sv
// Aho-Corasick stream matcher: run-time loadable goto/failure tables, one character per handshake.
// Optional saturating match counter on match_count when AC_MATCH_COUNT_EN is defined.
module ac_stream_matcher #(
  parameter int STATE_W = 8,
  parameter int CHAR_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHAR_W-1:0]         in_char,
  input  logic                      restart,
  input  logic                      load_en,
  input  logic                      load_sel,
  input  logic [STATE_W+CHAR_W-1:0] load_addr,
  input  logic [STATE_W+1:0]        load_data,
  output logic                      match,
  output logic [STATE_W-1:0]        match_state,
  output logic [STATE_W-1:0]        now_state,
  output logic                      busy
`ifdef AC_MATCH_COUNT_EN
  , output logic [15:0]             match_count
`endif
);

  localparam int AW = STATE_W + CHAR_W;
  localparam int GW = STATE_W + 2;

  typedef enum logic [1:0] {IDLE, CHECK, FAIL} st_t;

  logic [GW-1:0]      goto_mem [0:(1<<AW)-1];
  logic [STATE_W-1:0] fail_mem [0:(1<<STATE_W)-1];

  st_t                state_q, state_d;
  logic [STATE_W-1:0] now_q, now_d;
  logic [STATE_W-1:0] faddr_q, faddr_d;
  logic [STATE_W-1:0] mstate_q, mstate_d;
  logic [AW-1:0]      gaddr_q, gaddr_d;
  logic [CHAR_W-1:0]  char_q, char_d;
  logic               match_q, match_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [GW-1:0]      goto_rd;
  logic [STATE_W-1:0] fail_rd;
  logic               idle;
  logic               accept;

  // Registered read addresses give the 1-cycle read latency; holding them while en=0
  // keeps the pending read data available on resume.
  assign goto_rd  = goto_mem[gaddr_q];
  assign fail_rd  = fail_mem[faddr_q];
  assign idle     = (state_q == IDLE);
  assign in_ready = en & idle & ~load_en & ~restart;
  assign accept   = in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (en && idle && load_en) begin
      if (!load_sel) goto_mem[load_addr] <= load_data;
      else           fail_mem[load_addr[STATE_W-1:0]] <= load_data[STATE_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    now_d    = now_q;
    faddr_d  = faddr_q;
    mstate_d = mstate_q;
    gaddr_d  = gaddr_q;
    char_d   = char_q;
    match_d  = match_q;
    cnt_d    = cnt_q;
    if (en) begin
      match_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (restart) begin
            now_d = '0;
            cnt_d = '0;
          end else if (accept) begin
            char_d  = in_char;
            gaddr_d = {now_q, in_char};
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (goto_rd[GW-1]) begin
            now_d   = goto_rd[STATE_W-1:0];
            match_d = goto_rd[STATE_W];
            if (goto_rd[STATE_W]) mstate_d = goto_rd[STATE_W-1:0];
            state_d = IDLE;
          end else if (now_q == '0) begin
            state_d = IDLE;
          end else begin
            faddr_d = now_q;
            state_d = FAIL;
          end
        end
        FAIL: begin
          now_d   = fail_rd;
          gaddr_d = {fail_rd, char_q};
          state_d = CHECK;
        end
        default: state_d = IDLE;
      endcase
      if (match_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      now_q    <= '0;
      faddr_q  <= '0;
      mstate_q <= '0;
      gaddr_q  <= '0;
      char_q   <= '0;
      match_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      now_q    <= now_d;
      faddr_q  <= faddr_d;
      mstate_q <= mstate_d;
      gaddr_q  <= gaddr_d;
      char_q   <= char_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_state = mstate_q;
  assign now_state   = now_q;
  assign busy        = ~idle;

`ifdef AC_MATCH_COUNT_EN
  assign match_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_ac_stream_matcher.sv
// Scoreboard bench for ac_stream_matcher using the "he"/"she" dictionary (h=1, e=2, s=3).
module tb_ac_stream_matcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_char = '0;
  logic        restart = 1'b0;
  logic        load_en = 1'b0;
  logic        load_sel = 1'b0;
  logic [11:0] load_addr = '0;
  logic [9:0]  load_data = '0;
  logic        match;
  logic [7:0]  match_state;
  logic [7:0]  now_state;
  logic        busy;
`ifdef AC_MATCH_COUNT_EN
  logic [15:0] match_count;
`endif

  ac_stream_matcher #(.STATE_W(8), .CHAR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .restart(restart), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .match(match),
    .match_state(match_state), .now_state(now_state), .busy(busy)
`ifdef AC_MATCH_COUNT_EN
    , .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] now;
    logic       mt;
    logic [7:0] mst;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [9:0]  m_goto [0:4095];
  logic [7:0]  m_fail [0:255];
  logic [7:0]  m_now = '0;
  logic [7:0]  m_mst = '0;
  logic [15:0] m_cnt = '0;
  int          n_vec = 0;
  int          n_err = 0;

  // Reference walk: follow failure links until a goto hit or a miss at root.
  task automatic model_step(input logic [3:0] ch, output exp_t e);
    logic [7:0] cur;
    logic [9:0] g;
    int hops;
    cur = m_now;
    hops = 0;
    e.mt = 1'b0;
    for (int k = 0; k < 256; k++) begin
      g = m_goto[{cur, ch}];
      if (g[9]) begin
        cur = g[7:0];
        e.mt = g[8];
        break;
      end else if (cur == 8'd0) begin
        break;
      end else begin
        cur = m_fail[cur];
        hops++;
      end
    end
    m_now = cur;
    if (e.mt) begin
      m_mst = cur;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.now = cur;
    e.mst = m_mst;
    e.lat = 2 + 2 * hops;
  endtask

  task automatic load(input logic sel, input logic [11:0] a, input logic [9:0] d);
    load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
    if (!sel) m_goto[a] = d;
    else      m_fail[a[7:0]] = d[7:0];
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where in_ready is back.
  task automatic send(input logic [3:0] ch, input int freeze_at, input int restart_at);
    exp_t e, x;
    int n, w, lat;
    logic [7:0] frz;
    w = 0;
    frz = '0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL ready_wait: in_ready=%0b required 1", in_ready);
      return;
    end
    in_valid = 1'b1; in_char = ch;
    model_step(ch, e);
    sb.push_back(e);
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk); n++;
      if (n == freeze_at) begin en = 1'b0; frz = now_state; end
      if (freeze_at > 0 && n == freeze_at + 3) en = 1'b1;
      if (n == restart_at) restart = 1'b1;
      if (restart_at > 0 && n == restart_at + 1) restart = 1'b0;
      #1;
      if (freeze_at > 0 && n == freeze_at + 2) begin
        n_vec++;
        if (now_state !== frz || busy !== 1'b1) begin
          n_err++;
          $display("FAIL freeze_hold: now=%0d busy=%0b required now=%0d busy=1", now_state, busy, frz);
        end
      end
      if (in_ready) break;
    end
    x = sb.pop_front();
    lat = x.lat + ((freeze_at > 0) ? 3 : 0);
    n_vec += 4;
    if (n !== lat) begin n_err++; $display("FAIL latency ch=%0d: got %0d required %0d", ch, n, lat); end
    if (now_state !== x.now) begin n_err++; $display("FAIL now_state ch=%0d: got %0d required %0d", ch, now_state, x.now); end
    if (match !== x.mt) begin n_err++; $display("FAIL match ch=%0d: got %0b required %0b", ch, match, x.mt); end
    if (match_state !== x.mst) begin n_err++; $display("FAIL match_state ch=%0d: got %0d required %0d", ch, match_state, x.mst); end
`ifdef AC_MATCH_COUNT_EN
    n_vec++;
    if (match_count !== m_cnt) begin n_err++; $display("FAIL match_count: got %0d required %0d", match_count, m_cnt); end
`endif
  endtask

  task automatic do_restart();
    restart = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_during_restart: got %0b required 0", in_ready); end
    @(negedge clk);
    restart = 1'b0;
    m_now = '0; m_cnt = '0;
    #1;
    n_vec++;
    if (now_state !== 8'd0) begin n_err++; $display("FAIL restart_state: got %0d required 0", now_state); end
`ifdef AC_MATCH_COUNT_EN
    n_vec++;
    if (match_count !== 16'd0) begin n_err++; $display("FAIL restart_count: got %0d required 0", match_count); end
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    n_vec += 5;
    if (now_state !== 8'd0) begin n_err++; $display("FAIL %s now_state: got %0d required 0", tag, now_state); end
    if (match !== 1'b0) begin n_err++; $display("FAIL %s match: got %0b required 0", tag, match); end
    if (match_state !== 8'd0) begin n_err++; $display("FAIL %s match_state: got %0d required 0", tag, match_state); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy: got %0b required 0", tag, busy); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready: got %0b required 1", tag, in_ready); end
`ifdef AC_MATCH_COUNT_EN
    n_vec++;
    if (match_count !== 16'd0) begin n_err++; $display("FAIL %s match_count: got %0d required 0", tag, match_count); end
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("reset");
  endtask

  task automatic test_load();
    load_en = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_during_load: got %0b required 0", in_ready); end
    @(negedge clk);
    for (int a = 0; a < 4096; a++) load(1'b0, a[11:0], 10'd0);
    load(1'b0, {8'd0, 4'd1}, {2'b10, 8'd1});
    load(1'b0, {8'd1, 4'd2}, {2'b11, 8'd2});
    load(1'b0, {8'd0, 4'd3}, {2'b10, 8'd3});
    load(1'b0, {8'd3, 4'd1}, {2'b10, 8'd4});
    load(1'b0, {8'd4, 4'd2}, {2'b11, 8'd5});
    load(1'b1, 12'd1, 10'd0);
    load(1'b1, 12'd2, 10'd0);
    load(1'b1, 12'd3, 10'd0);
    load(1'b1, 12'd4, 10'd1);
    load(1'b1, 12'd5, 10'd2);
  endtask

  task automatic test_direct();
    do_restart();
    send(4'd3, -1, -1);
    send(4'd1, -1, -1);
    send(4'd2, -1, -1);
    @(negedge clk); #1;
    n_vec++;
    if (match !== 1'b0) begin n_err++; $display("FAIL match_one_cycle: got %0b required 0", match); end
  endtask

  task automatic test_fail_hops();
    do_restart();
    send(4'd3, -1, -1);
    send(4'd1, -1, -1);
    send(4'd3, -1, -1);
  endtask

  task automatic test_he_he();
    do_restart();
    send(4'd1, -1, -1);
    send(4'd2, -1, -1);
    send(4'd1, -1, -1);
    send(4'd2, -1, -1);
  endtask

  task automatic test_root_miss_restart();
    do_restart();
    send(4'd2, -1, -1);
    send(4'd3, -1, -1);
    send(4'd1, -1, -1);
    do_restart();
    send(4'd3, -1, 1);
  endtask

  task automatic test_en_freeze();
    do_restart();
    send(4'd3, -1, -1);
    send(4'd1, -1, -1);
    send(4'd3, 2, -1);
  endtask

  task automatic test_reset_mid();
    exp_t dummy;
    do_restart();
    in_valid = 1'b1; in_char = 4'd3;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_in_check: got %0b required 1", busy); end
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_now = '0; m_mst = '0; m_cnt = '0;
    dummy.lat = 0;
    @(negedge clk);
    send(4'd3, -1, -1);
    send(4'd1, -1, -1);
    send(4'd2, -1, -1);
  endtask

  task automatic test_back_to_back();
    do_restart();
    for (int i = 0; i < 40; i++) send(4'($urandom_range(0, 4)), -1, -1);
  endtask

  initial begin
    test_reset();
    test_load();
    test_direct();
    test_fail_hops();
    test_he_he();
    test_root_miss_restart();
    test_en_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ac_stream_matcher.md
# ac_stream_matcher

Parametrised Aho-Corasick stream engine: the single-block successor to the fixed 8-bit-state / 4-bit-character goto/failure/match datapath. It consumes one character per valid/ready handshake and walks the automaton, following failure links over multiple cycles when no goto edge exists. It flags matches from a per-state output bit. The goto and failure tables are internal, loaded at run time through a write port, so one netlist serves any dictionary that fits STATE_W/CHAR_W.

## Interface
- STATE_W, 8, state id width; 2^STATE_W states, state 0 = root
- CHAR_W, 4, character width; 2^CHAR_W symbols
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  global enable; 0 freezes FSM, state and counters (outputs hold)
- IN_VALID  in  1  character valid
- IN_READY  out  1  engine accepts character this cycle
- IN_CHAR  in  CHAR_W  input character
- RESTART  in  1  one-cycle pulse: return current state to root (new stream)
- LOAD_EN  in  1  table write strobe
- LOAD_SEL  in  1  0 = goto table, 1 = failure table
- LOAD_ADDR  in  STATE_W+CHAR_W  goto: {state,char}; failure: low STATE_W bits = state
- LOAD_DATA  in  STATE_W+2  goto: {valid,out,next}; failure: low STATE_W bits = fail state
- MATCH  out  1  one-cycle pulse: entered a state with out=1
- MATCH_STATE  out  STATE_W  state entered when MATCH pulsed
- NOW_STATE  out  STATE_W  current automaton state
- BUSY  out  1  FSM not in IDLE
- MATCH_COUNT  out  16  saturating match count (only with AC_MATCH_COUNT_EN)

## Operation
- Tables: goto RAM of 2^(STATE_W+CHAR_W) x (STATE_W+2) and failure RAM of 2^STATE_W x STATE_W. Both use synchronous read with 1-cycle latency and are not reset. The out bit must be loaded to include suffix (dictionary-link) matches.
- FSM states: IDLE, CHECK, FAIL.
- IDLE: IN_READY = EN & ~LOAD_EN & ~RESTART.
  - On handshake: latch IN_CHAR, issue goto read {NOW_STATE, IN_CHAR}, go to CHECK.
  - LOAD_EN writes the selected table; it is honoured only in IDLE and ignored elsewhere.
- CHECK, goto entry valid: NOW_STATE <= next. If out=1, MATCH=1 and MATCH_STATE=next on the following cycle. Go to IDLE.
- CHECK, invalid and NOW_STATE=0: stay at root, no match, go to IDLE.
- CHECK, invalid and NOW_STATE≠0: issue failure read at NOW_STATE, go to FAIL.
- FAIL: NOW_STATE <= fail data, issue goto read {fail data, latched char}, go to CHECK.
- RESTART in IDLE: NOW_STATE <= 0, no match. RESTART outside IDLE is ignored; the in-flight character completes.
- EN=0: all registers hold. Pending RAM read data is re-issued on EN rise, so no data is lost.
- Failure chains must strictly decrease depth; a cyclic failure table is a load error and is not detected.

## Timing
- Reset values: NOW_STATE=0, FSM=IDLE, MATCH=0, MATCH_STATE=0, BUSY=0, MATCH_COUNT=0. IN_READY=1 once RST deasserts, provided EN=1 and LOAD_EN=0.
- Direct goto hit:
  - accept at T, CHECK at T+1.
  - NOW_STATE/MATCH visible at T+2; IN_READY high again at T+2.
  - Throughput is 1 character per 2 cycles.
- Each failure hop adds 2 cycles (FAIL + CHECK). Worst case is 2 + 2·depth cycles.
- MATCH is high exactly one cycle per matching transition.
- Load write takes effect in its cycle; a read in the next cycle sees the new data.

## Configuration
- AC_MATCH_COUNT_EN defined: MATCH_COUNT port exists.
  - Increments on every MATCH pulse and saturates at 16'hFFFF.
  - Cleared by reset and by RESTART.
- Undefined: MATCH_COUNT port and counter are absent; all other behaviour is identical.

## Test plan
Dictionary "he","she" with h=1, e=2, s=3. Goto edges: 0-1→1, 1-2→2(out), 0-3→3, 3-1→4, 4-2→5(out). Failure table: 1→0, 2→0, 3→0, 4→1, 5→2.
- Stream 3,1,2 → NOW_STATE 3,4,5; MATCH once with MATCH_STATE=5; each character takes 2 cycles.
- Stream 3,1,3 from state 4 → two failure hops (4→1→0) then goto to 3. IN_READY low for 6 cycles, NOW_STATE=3, no MATCH.
- Stream 1,2,1,2 → MATCH at states 2 and 2; MATCH_COUNT=2 (with AC_MATCH_COUNT_EN).
- Character 2 at root → stays at 0 in 2 cycles with no FAIL state entered. RESTART at state 4 → NOW_STATE=0.
- EN dropped during FAIL for 3 cycles → state frozen; on resume, final result is identical to the uninterrupted run.
- RST asserted mid-CHECK → all outputs at reset values immediately; tables are retained and matching works after release without reload.
